// File: rtl/timer_ctrl_if.sv
// Bus between the control/register logic plus the external counter (master side)
// and the timer sequencer (slave side).
// Command semantics: start and stop are level-sampled commands with no ready
// return; a command is taken on any posedge where it is high and the current
// state accepts it, and stop takes precedence over start in every state.
interface timer_ctrl_if #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
);
    logic                  start;
    logic                  stop;
    logic                  mode;
    logic [WIDTH-1:0]      cmp_val;
    logic [PRESCALE_W-1:0] prescale;
    logic [WIDTH-1:0]      cnt_val;
    logic                  irq_ack;
    logic                  cnt_clr;
    logic                  cnt_en;
    logic                  busy;
    logic                  tick;
    logic                  irq;
    logic [1:0]            dbg_state;

    modport master (
        output start, stop, mode, cmp_val, prescale, cnt_val, irq_ack,
        input  cnt_clr, cnt_en, busy, tick, irq, dbg_state
    );

    modport slave (
        input  start, stop, mode, cmp_val, prescale, cnt_val, irq_ack,
        output cnt_clr, cnt_en, busy, tick, irq, dbg_state
    );
endinterface

// File: rtl/timer_ctrl.sv
// Sequencer for an external up-counter: clears/enables the counter, divides the
// count rate by a prescaler, detects the compare terminal count, and raises a
// terminal tick plus a sticky interrupt. Outputs depend only on registered state,
// the prescaler and the counter value.
module timer_ctrl #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic         clk,
    input  logic         reset,
    timer_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [PRESCALE_W-1:0] psc;
    logic                  mode_lat;
    logic [WIDTH-1:0]      cmp_lat;
    logic [PRESCALE_W-1:0] prescale_lat;
    logic                  irq_r;
    logic                  strobe;
    logic                  term;
    logic                  latch_cfg;

    // Prescaler strobe and terminal-count detect.
    always_comb begin
        strobe = (state == RUN) && (psc == prescale_lat);
        term   = strobe && (bus.cnt_val == cmp_lat);
    end

    // Next-state and output decode; outputs never look at start/stop/irq_ack.
    always_comb begin
        state_nxt   = state;
        latch_cfg   = 1'b0;
        bus.cnt_clr = 1'b0;
        bus.cnt_en  = 1'b0;
        bus.busy    = 1'b0;
        bus.tick    = 1'b0;
        case (state)
            IDLE: begin
                bus.cnt_clr = 1'b1;
                if (bus.start && !bus.stop) begin
                    latch_cfg = 1'b1;
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                bus.cnt_clr = 1'b1;
                bus.busy    = 1'b1;
                state_nxt   = bus.stop ? IDLE : RUN;
            end
            RUN: begin
                bus.busy    = 1'b1;
                bus.cnt_en  = strobe && !term;
                bus.tick    = term;
                // Periodic mode restarts the counter on the terminal cycle itself.
                bus.cnt_clr = term && mode_lat;
                if (bus.stop) begin
                    state_nxt = IDLE;
                end else if (term && !mode_lat) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.stop) begin
                    state_nxt = IDLE;
                end else if (bus.start) begin
                    latch_cfg = 1'b1;
                    state_nxt = CLEAR;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Prescaler: counts 0..prescale_lat while staying in RUN, otherwise held at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            psc <= '0;
        end else if (state == RUN && state_nxt == RUN && !strobe) begin
            psc <= psc + 1'b1;
        end else begin
            psc <= '0;
        end
    end

    // Configuration snapshot taken when a run is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_lat     <= 1'b0;
            cmp_lat      <= '0;
            prescale_lat <= '0;
        end else if (latch_cfg) begin
            mode_lat     <= bus.mode;
            cmp_lat      <= bus.cmp_val;
            prescale_lat <= bus.prescale;
        end
    end

    // Sticky interrupt: a tick wins over a simultaneous acknowledge.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_r <= 1'b0;
        end else if (bus.tick) begin
            irq_r <= 1'b1;
        end else if (bus.irq_ack) begin
            irq_r <= 1'b0;
        end
    end

    // Registered status exported on the bus.
    always_comb begin
        bus.irq       = irq_r;
        bus.dbg_state = state;
    end
endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: drives directed and randomized runs against an
// arithmetic reference (tick cycles, counter value, enables per cycle).
module tb_timer_ctrl;
    localparam int WIDTH = 8;
    localparam int PW    = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] ext_cnt = '0;
    int               checks = 0;
    int               failures = 0;
    logic             exp_irq = 1'b0;
    logic [15:0]      exp_q[$];

    timer_ctrl_if #(.WIDTH(WIDTH), .PRESCALE_W(PW)) bus();

    timer_ctrl #(.WIDTH(WIDTH), .PRESCALE_W(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // clock
    always #5 clk = ~clk;

    // external counter the sequencer controls
    assign bus.cnt_val = ext_cnt;
    always @(posedge clk) begin
        if (bus.cnt_clr === 1'b1) ext_cnt <= '0;
        else if (bus.cnt_en === 1'b1) ext_cnt <= ext_cnt + 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, k, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input int k);
        chk({tag, "_clr"},  k, 32'(bus.cnt_clr), 32'd1);
        chk({tag, "_en"},   k, 32'(bus.cnt_en),  32'd0);
        chk({tag, "_busy"}, k, 32'(bus.busy),    32'd0);
        chk({tag, "_tick"}, k, 32'(bus.tick),    32'd0);
    endtask

    task automatic go_idle();
        bus.start = 1'b0;
        bus.stop  = 1'b1;
        step();
        bus.stop  = 1'b0;
    endtask

    // One run starting with start in cycle 0. Optional stop/reset/ack cycles (0 = none).
    task automatic run(input bit m, input int c, input int p, input int len, input int cnt0,
                       input int stop_at, input int rst_at, input int ack1, input int ack2);
        int  t, j, ph, exp_cnt, abort_k, cut;
        bit  aborted, done, strobe, e_tick, e_en, e_clr, e_busy, ack;
        t = (c + 1) * (p + 1);
        cut = len;
        if (stop_at != 0 && stop_at < cut) cut = stop_at;
        if (rst_at != 0 && rst_at < cut) cut = rst_at;
        exp_q.delete();
        if (m) begin
            for (int n = 1; 1 + n * t <= cut; n++) exp_q.push_back(16'(1 + n * t));
        end else if (1 + t <= cut) begin
            exp_q.push_back(16'(1 + t));
        end
        bus.mode     = m;
        bus.cmp_val  = WIDTH'(c);
        bus.prescale = PW'(p);
        bus.start    = 1'b1;
        bus.stop     = 1'b0;
        bus.irq_ack  = 1'b1;
        step();
        exp_irq = 1'b0;
        aborted = 1'b0;
        abort_k = 0;
        for (int k = 1; k <= len; k++) begin
            e_tick = (exp_q.size() != 0) && (int'(exp_q[0]) == k);
            if (e_tick) void'(exp_q.pop_front());
            if (aborted) begin
                chk_idle("abort", k);
                if (k > abort_k + 1) chk("abort_cnt", k, 32'(bus.cnt_val), 32'd0);
            end else begin
                if (k == 1) begin
                    e_clr = 1; e_en = 0; e_busy = 1; exp_cnt = cnt0;
                end else begin
                    j    = k - 2;
                    done = !m && (j >= t);
                    if (done) begin
                        e_clr = 0; e_en = 0; e_busy = 0; exp_cnt = c;
                    end else begin
                        ph      = j % t;
                        exp_cnt = ph / (p + 1);
                        strobe  = (ph % (p + 1)) == p;
                        e_en    = strobe && !e_tick;
                        e_clr   = e_tick && m;
                        e_busy  = 1;
                    end
                end
                chk("tick", k, 32'(bus.tick),    32'(e_tick));
                chk("en",   k, 32'(bus.cnt_en),  32'(e_en));
                chk("clr",  k, 32'(bus.cnt_clr), 32'(e_clr));
                chk("busy", k, 32'(bus.busy),    32'(e_busy));
                chk("cnt",  k, 32'(bus.cnt_val), 32'(exp_cnt));
            end
            chk("irq", k, 32'(bus.irq), 32'(exp_irq));
            // inputs for this cycle; config churn must not matter mid-run
            ack          = (k == ack1) || (k == ack2);
            bus.irq_ack  = ack;
            bus.stop     = (k == stop_at);
            reset        = (k == rst_at);
            bus.start    = (!aborted && (m || k < 1 + t)) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.mode     = 1'($urandom_range(0, 1));
            bus.cmp_val  = WIDTH'($urandom);
            bus.prescale = PW'($urandom);
            if (k == rst_at) exp_irq = 1'b0;
            else if (e_tick) exp_irq = 1'b1;
            else if (ack) exp_irq = 1'b0;
            if (k == stop_at || k == rst_at) begin
                aborted = 1'b1;
                abort_k = k;
            end
            step();
        end
        chk("tick_q_empty", len, 32'(exp_q.size()), 32'd0);
        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.irq_ack = 1'b0;
    endtask

    initial begin
        int rm, rc, rp, rlen, rstop;
        bus.start = 0; bus.stop = 0; bus.mode = 0; bus.cmp_val = '0;
        bus.prescale = '0; bus.irq_ack = 0;
        // reset held for two cycles
        reset = 1'b1;
        step();
        step();
        chk_idle("rst", 0);
        chk("rst_irq", 0, 32'(bus.irq), 32'd0);
        reset = 1'b0;
        step();
        chk_idle("post_rst", 0);
        chk("post_rst_irq", 0, 32'(bus.irq), 32'd0);

        // one-shot cmp=3 prescale=1, then restart from DONE in periodic cmp=2 prescale=0
        go_idle();
        run(1'b0, 3, 1, 14, 0, 0, 0, 0, 0);
        run(1'b1, 2, 0, 14, 3, 0, 0, 0, 0);

        // ack coinciding with a periodic tick, then ack alone
        go_idle();
        run(1'b1, 2, 0, 14, 0, 0, 0, 7, 8);

        // stop in cycle 6 of a one-shot run
        go_idle();
        run(1'b0, 3, 1, 14, 0, 6, 0, 0, 0);

        // start and stop together from IDLE
        go_idle();
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step();
        chk_idle("startstop", 1);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        step();
        chk_idle("startstop", 2);

        // full-range compare, then reset mid-run
        go_idle();
        run(1'b0, 255, 0, 262, 0, 0, 0, 0, 0);
        go_idle();
        run(1'b0, 255, 0, 110, 0, 0, 100, 0, 0);

        // randomized runs
        for (int r = 0; r < 12; r++) begin
            rm    = $urandom_range(0, 1);
            rc    = $urandom_range(0, 12);
            rp    = $urandom_range(0, 3);
            rlen  = rm ? 3 * (rc + 1) * (rp + 1) + 2 : (rc + 1) * (rp + 1) + 4;
            rstop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, (rc + 1) * (rp + 1) + 1) : 0;
            go_idle();
            run(1'(rm), rc, rp, rlen, 0, rstop, 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
